// File: rtl/image_frame_monitor_pkg.sv
// rtl/image_frame_monitor_pkg.sv - shared types and constants for the frame monitor
package image_frame_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LINE,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_ABORT = 2;

    localparam int ACC_W = 28;
    localparam int INT_W = 10;

    function automatic logic [INT_W-1:0] intensity(input logic [7:0] r, input logic [7:0] g,
                                                   input logic [7:0] b);
        return INT_W'(r) + INT_W'(g) + INT_W'(b);
    endfunction

endpackage

// File: rtl/image_frame_monitor_if.sv
// rtl/image_frame_monitor_if.sv - VSYNC/HSYNC qualified 2-pixel RGB888 video stream
interface image_frame_monitor_if;
    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] DATA_R1;
    logic [7:0] DATA_G1;
    logic [7:0] DATA_B1;

    modport master (output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1);
    modport slave  (input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1);
endinterface

// File: rtl/image_frame_monitor_pix_stat_accum.sv
// rtl/image_frame_monitor_pix_stat_accum.sv - per-beat channel sum and intensity min/max datapath
module pix_stat_accum
    import image_frame_monitor_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       r0,
    input  logic [7:0]       g0,
    input  logic [7:0]       b0,
    input  logic [7:0]       r1,
    input  logic [7:0]       g1,
    input  logic [7:0]       b1,
    output logic [ACC_W-1:0] sum_r,
    output logic [ACC_W-1:0] sum_g,
    output logic [ACC_W-1:0] sum_b,
    output logic [INT_W-1:0] int_min,
    output logic [INT_W-1:0] int_max
);

    logic [INT_W-1:0] i0, i1, lo, hi;

    assign i0 = intensity(r0, g0, b0);
    assign i1 = intensity(r1, g1, b1);
    assign lo = (i0 < i1) ? i0 : i1;
    assign hi = (i0 < i1) ? i1 : i0;

    // min starts at full scale so the first counted pixel always replaces it
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            int_min <= '1;
            int_max <= '0;
        end else if (clr) begin
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            int_min <= '1;
            int_max <= '0;
        end else if (en) begin
            sum_r <= sum_r + ACC_W'(r0) + ACC_W'(r1);
            sum_g <= sum_g + ACC_W'(g0) + ACC_W'(g1);
            sum_b <= sum_b + ACC_W'(b0) + ACC_W'(b1);
            if (lo < int_min) int_min <= lo;
            if (hi > int_max) int_max <= hi;
        end
    end

endmodule

// File: rtl/image_frame_monitor.sv
// rtl/image_frame_monitor.sv - passive frame geometry checker and statistics collector
module image_frame_monitor
    import image_frame_monitor_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int GAP_TIMEOUT = 1023
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    image_frame_monitor_if.slave   vid,
    output logic                   frame_done,
    output logic                   frame_ok,
    output logic [2:0]             err_code,
    output logic [9:0]             line_cnt,
    output logic [ACC_W-1:0]       sum_r,
    output logic [ACC_W-1:0]       sum_g,
    output logic [ACC_W-1:0]       sum_b,
    output logic [INT_W-1:0]       int_min,
    output logic [INT_W-1:0]       int_max,
    output logic                   busy
);

    localparam int BEATS = WIDTH / 2;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int GW    = $clog2(GAP_TIMEOUT + 1);
    localparam logic [BW-1:0] BEATS_L  = BW'(BEATS);
    localparam logic [9:0]    HEIGHT_L = 10'(HEIGHT);
    localparam logic [GW-1:0] GAP_L    = GW'(GAP_TIMEOUT);

    state_t          state_q, state_d;
    logic            vsync_d, start;
    logic [BW-1:0]   beat_q, beat_d;
    logic [9:0]      line_q, line_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [2:0]      err_q, err_d;
    logic            acc_clr, acc_en, load;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b;
    logic [INT_W-1:0] acc_min, acc_max;

    assign start = vid.VSYNC & ~vsync_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            vsync_d <= 1'b0;
            beat_q  <= '0;
            line_q  <= '0;
            gap_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vsync_d <= vid.VSYNC;
            beat_q  <= beat_d;
            line_q  <= line_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        gap_d   = gap_q;
        err_d   = err_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_ARMED;
                beat_d  = '0;
                line_d  = '0;
                gap_d   = '0;
                err_d   = '0;
                acc_clr = 1'b1;
            end
            ST_ARMED: if (start) begin
                err_d[ERR_ABORT] = 1'b1;
                state_d = ST_DONE;
            end else if (vid.HSYNC) begin
                beat_d  = BW'(1);
                acc_en  = 1'b1;
                state_d = ST_LINE;
            end
            ST_LINE: if (start) begin
                err_d[ERR_ABORT] = 1'b1;
                state_d = ST_DONE;
            end else if (vid.HSYNC) begin
                // beats past the nominal width flag the line but never reach the sums
                if (beat_q == BEATS_L) begin
                    err_d[ERR_LONG] = 1'b1;
                end else begin
                    beat_d = beat_q + BW'(1);
                    acc_en = 1'b1;
                end
            end else begin
                line_d = line_q + 10'd1;
                if (beat_q != BEATS_L) err_d[ERR_SHORT] = 1'b1;
                beat_d  = '0;
                gap_d   = '0;
                state_d = (line_d == HEIGHT_L) ? ST_DONE : ST_GAP;
            end
            ST_GAP: if (start) begin
                err_d[ERR_ABORT] = 1'b1;
                state_d = ST_DONE;
            end else if (vid.HSYNC) begin
                beat_d  = BW'(1);
                gap_d   = '0;
                acc_en  = 1'b1;
                state_d = ST_LINE;
            end else if (gap_q == GAP_L) begin
                err_d[ERR_ABORT] = 1'b1;
                state_d = ST_DONE;
            end else begin
                gap_d = gap_q + GW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // results are captured on the edge entering DONE so they are valid alongside frame_done
    assign load = (state_d == ST_DONE) && (state_q != ST_DONE);

    pix_stat_accum u_accum (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr     (acc_clr),
        .en      (acc_en),
        .r0      (vid.DATA_R0),
        .g0      (vid.DATA_G0),
        .b0      (vid.DATA_B0),
        .r1      (vid.DATA_R1),
        .g1      (vid.DATA_G1),
        .b1      (vid.DATA_B1),
        .sum_r   (acc_r),
        .sum_g   (acc_g),
        .sum_b   (acc_b),
        .int_min (acc_min),
        .int_max (acc_max)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            frame_ok <= 1'b0;
            err_code <= '0;
            line_cnt <= '0;
            sum_r    <= '0;
            sum_g    <= '0;
            sum_b    <= '0;
            int_min  <= '0;
            int_max  <= '0;
        end else if (load) begin
            frame_ok <= (err_d == 3'b000);
            err_code <= err_d;
            line_cnt <= line_d;
            sum_r    <= acc_r;
            sum_g    <= acc_g;
            sum_b    <= acc_b;
            int_min  <= acc_min;
            int_max  <= acc_max;
        end
    end

    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_image_frame_monitor.sv
// tb/tb_image_frame_monitor.sv - self-checking bench for image_frame_monitor
module tb_image_frame_monitor;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int GT  = 15;
    localparam int BPL = W / 2;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    image_frame_monitor_if vid ();

    logic        frame_done, frame_ok, busy;
    logic [2:0]  err_code;
    logic [9:0]  line_cnt;
    logic [27:0] sum_r, sum_g, sum_b;
    logic [9:0]  int_min, int_max;

    image_frame_monitor #(.WIDTH(W), .HEIGHT(H), .GAP_TIMEOUT(GT)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .vid        (vid),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_code   (err_code),
        .line_cnt   (line_cnt),
        .sum_r      (sum_r),
        .sum_g      (sum_g),
        .sum_b      (sum_b),
        .int_min    (int_min),
        .int_max    (int_max),
        .busy       (busy)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // reference model: expected frame statistics
    longint   e_r, e_g, e_b;
    int       e_min, e_max, e_lines;
    logic [2:0] e_err;
    int       lens[H];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic model_clear;
        e_r = 0; e_g = 0; e_b = 0;
        e_min = 1023; e_max = 0; e_lines = 0; e_err = 3'b000;
    endtask

    task automatic drive_beat(input int mode, input bit counted);
        int p[6];
        int i0, i1;
        for (int k = 0; k < 6; k++)
            p[k] = (mode == 0) ? ((k % 3) + 1) * 10 : int'($urandom_range(0, 255));
        vid.HSYNC = 1'b1;
        vid.DATA_R0 = 8'(p[0]); vid.DATA_G0 = 8'(p[1]); vid.DATA_B0 = 8'(p[2]);
        vid.DATA_R1 = 8'(p[3]); vid.DATA_G1 = 8'(p[4]); vid.DATA_B1 = 8'(p[5]);
        if (counted) begin
            e_r += p[0] + p[3]; e_g += p[1] + p[4]; e_b += p[2] + p[5];
            i0 = p[0] + p[1] + p[2];
            i1 = p[3] + p[4] + p[5];
            if (i0 < e_min) e_min = i0;
            if (i1 < e_min) e_min = i1;
            if (i0 > e_max) e_max = i0;
            if (i1 > e_max) e_max = i1;
        end
        tick();
    endtask

    // drives a line's beats and leaves HSYNC low; the caller advances time
    task automatic drive_line(input int nbeats, input int mode);
        for (int b = 0; b < nbeats; b++) drive_beat(mode, b < BPL);
        e_lines++;
        if (nbeats < BPL) e_err[0] = 1'b1;
        if (nbeats > BPL) e_err[1] = 1'b1;
        vid.HSYNC = 1'b0;
    endtask

    task automatic start_frame;
        vid.VSYNC = 1'b0; tick();
        vid.VSYNC = 1'b1; tick(); tick();
        vid.VSYNC = 1'b0; tick();
        model_clear();
    endtask

    task automatic check_done(input string t);
        chk({t, "_done"},     64'(frame_done), 64'd1);
        chk({t, "_ok"},       64'(frame_ok),   64'(e_err == 3'b000));
        chk({t, "_err"},      64'(err_code),   64'(e_err));
        chk({t, "_lines"},    64'(line_cnt),   64'(e_lines));
        chk({t, "_sum_r"},    64'(sum_r),      64'(e_r));
        chk({t, "_sum_g"},    64'(sum_g),      64'(e_g));
        chk({t, "_sum_b"},    64'(sum_b),      64'(e_b));
        chk({t, "_min"},      64'(int_min),    64'(e_min));
        chk({t, "_max"},      64'(int_max),    64'(e_max));
        tick();
        chk({t, "_pulse_end"}, 64'(frame_done), 64'd0);
        chk({t, "_idle"},      64'(busy),       64'd0);
    endtask

    task automatic run_frame(input string t, input int mode);
        logic [9:0] held;
        held = line_cnt;
        start_frame();
        chk({t, "_armed_busy"}, 64'(busy), 64'd1);
        for (int k = 0; k < H; k++) begin
            drive_line(lens[k], mode);
            if (k < H - 1) begin
                if (mode == 0) repeat (10) tick();
                else repeat ($urandom_range(1, 10)) tick();
                if (k == 1) chk({t, "_held"}, 64'(line_cnt), 64'(held));
            end
        end
        tick();
        check_done(t);
    endtask

    initial begin
        int ticks;
        bit seen, act;
        vid.VSYNC = 1'b0; vid.HSYNC = 1'b0;
        vid.DATA_R0 = '0; vid.DATA_G0 = '0; vid.DATA_B0 = '0;
        vid.DATA_R1 = '0; vid.DATA_G1 = '0; vid.DATA_B1 = '0;
        tick(); tick();
        HRESETn = 1'b1;
        tick();
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_ok",   64'(frame_ok),   64'd0);
        chk("rst_busy", 64'(busy),       64'd0);
        chk("rst_min",  64'(int_min),    64'd0);
        chk("rst_sum",  64'(sum_r),      64'd0);

        // nominal uniform frame
        lens = '{4, 4, 4, 4};
        run_frame("nom", 0);
        chk("nom_sum_r_abs", 64'(sum_r), 64'd320);
        chk("nom_sum_g_abs", 64'(sum_g), 64'd640);
        chk("nom_sum_b_abs", 64'(sum_b), 64'd960);
        chk("nom_min_abs",   64'(int_min), 64'd60);
        chk("nom_max_abs",   64'(int_max), 64'd60);

        lens = '{4, 3, 4, 4};
        run_frame("short", 1);
        lens = '{5, 4, 4, 4};
        run_frame("long_u", 0);
        chk("long_sum_abs", 64'(sum_r), 64'd320);
        chk("long_err_abs", 64'(err_code), 64'd2);

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < H; k++) lens[k] = int'($urandom_range(BPL - 1, BPL + 1));
            run_frame($sformatf("rnd%0d", f), 1);
        end

        // restart during line 3
        start_frame();
        drive_line(4, 1); repeat (3) tick();
        drive_line(4, 1); repeat (3) tick();
        drive_beat(1, 1'b1);
        drive_beat(1, 1'b1);
        vid.VSYNC = 1'b1;
        e_err[2] = 1'b1;
        drive_beat(1, 1'b0);
        vid.HSYNC = 1'b0;
        check_done("restart");
        chk("restart_lines_abs", 64'(line_cnt), 64'd2);
        vid.VSYNC = 1'b0;
        lens = '{4, 4, 4, 4};
        run_frame("after_restart", 1);

        // gap timeout after line 1
        start_frame();
        drive_line(4, 1);
        e_err[2] = 1'b1;
        seen = 1'b0; ticks = 0;
        while (!seen && ticks < 60) begin
            tick(); ticks++;
            seen = frame_done;
        end
        chk("timeout_not_early", 64'(ticks > GT), 64'd1);
        check_done("timeout");

        // asynchronous reset mid-line
        start_frame();
        vid.HSYNC = 1'b1;
        tick(); tick();
        HRESETn = 1'b0;
        #2;
        chk("arst_done",  64'(frame_done), 64'd0);
        chk("arst_busy",  64'(busy),       64'd0);
        chk("arst_lines", 64'(line_cnt),   64'd0);
        chk("arst_err",   64'(err_code),   64'd0);
        chk("arst_sum",   64'(sum_g),      64'd0);
        chk("arst_max",   64'(int_max),    64'd0);
        tick();
        HRESETn = 1'b1;
        act = 1'b0;
        for (int c = 0; c < 30; c++) begin
            vid.HSYNC = 1'($urandom_range(0, 1));
            tick();
            if (busy || frame_done) act = 1'b1;
        end
        chk("no_vsync_activity", 64'(act), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
